timer_counter: RTL and testbench

- Memory-mapped programmable timer that generates the `interrupt` input of `mips`.
- Sits on the CPU's peripheral bridge, outside the CPU.
- The CPU programs it through three word registers: CTRL, PRESET and COUNT.
- The timer counts down from PRESET and raises `irq`, which the top level routes to the `mips` interrupt input as a hardware interrupt source for CP0.
- Supports one-shot mode and auto-reload (periodic) mode.

---
 rtl/timer_counter.sv | 120 ++++++++++++
 tb/tb_timer_counter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Drives the CPU hardware interrupt line through a maskable flag.
module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t             r_state;
  logic               r_en;
  logic [1:0]         r_mode;
  logic               r_im;
  logic               r_flag;
  logic [CNT_W-1:0]   r_preset;
  logic [CNT_W-1:0]   r_count;

  state_t             w_state_nxt;
  logic               w_en_nxt;
  logic               w_flag_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_ctrl_we;
  logic               w_pre_we;
  logic [31:0]        w_dout;
  logic               w_unused;

  assign w_ctrl_we = we && (addr[3:2] == 2'd0);
  assign w_pre_we  = we && (addr[3:2] == 2'd1);
  assign w_unused  = ^{addr[31:4], addr[1:0], din};

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = r_en;
    w_flag_nxt  = r_flag;
    w_count_nxt = r_count;
    unique case (r_state)
      S_IDLE: begin
        if (r_en) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_count > CNT_W'(1)) begin
          w_count_nxt = r_count - CNT_W'(1);
        end else begin
          w_count_nxt = '0;
          w_flag_nxt  = 1'b1;
          w_state_nxt = S_INT;
        end
      end
      S_INT: begin
        if (r_mode == 2'd1) begin
          w_flag_nxt  = 1'b0;
          w_state_nxt = r_en ? S_LOAD : S_IDLE;
        end else begin
          w_en_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A CPU write to CTRL overrides whatever the FSM decided this edge.
    if (w_ctrl_we) begin
      w_en_nxt   = din[0];
      w_flag_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_en     <= 1'b0;
      r_mode   <= 2'd0;
      r_im     <= 1'b0;
      r_flag   <= 1'b0;
      r_preset <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= w_en_nxt;
      r_flag  <= w_flag_nxt;
      r_count <= w_count_nxt;
      if (w_ctrl_we) begin
        r_mode <= din[2:1];
        r_im   <= din[3];
      end
      if (w_pre_we) r_preset <= din[CNT_W-1:0];
    end
  end

  always_comb begin
    w_dout = '0;
    case (addr[3:2])
      2'd0:    w_dout = {28'd0, r_im, r_mode, r_en};
      2'd1:    w_dout = 32'(r_preset);
      2'd2:    w_dout = 32'(r_count);
      default: w_dout = '0;
    endcase
  end

  assign dout = w_dout;
  assign irq  = r_flag & r_im;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios with literal expectations
// plus random traffic, all compared every cycle against a timeline model.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  timer_counter #(.CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // Model: m_k counts edges since the timer left idle.
  // k=1 is the load edge, the count shows L-(k-2), and the
  // interrupt position is k = 2 + max(L,1). k=0 means idle.
  logic        m_en = 0, m_im = 0, m_flag = 0;
  logic [1:0]  m_mode = 0;
  logic [31:0] m_pre = 0, m_cnt = 0, m_L = 0;
  int          m_k = 0;

  always @(posedge clk) begin : model
    logic        n_en, n_flag;
    logic [31:0] n_cnt;
    int          nk, t_int;
    if (reset) begin
      m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
      m_pre = 0; m_cnt = 0; m_L = 0; m_k = 0;
    end else begin
      n_en = m_en; n_flag = m_flag; n_cnt = m_cnt; nk = m_k;
      t_int = 2 + ((m_L == 0) ? 1 : int'(m_L));
      if (m_k == 0) begin
        if (m_en) nk = 1;
      end else if (m_k == 1) begin
        m_L = m_pre;
        n_cnt = m_pre;
        nk = 2;
      end else if (m_k == t_int) begin
        if (m_mode == 2'd1) begin
          n_flag = 0;
          nk = m_en ? 1 : 0;
        end else begin
          n_en = 0;
          nk = 0;
        end
      end else if (!m_en) begin
        nk = 0;
      end else begin
        nk = m_k + 1;
        if (nk == t_int) begin
          n_cnt = 0;
          n_flag = 1;
        end else begin
          n_cnt = m_L - 32'(nk - 2);
        end
      end
      if (we && addr[3:2] == 2'd0) begin
        n_en = din[0];
        m_mode = din[2:1];
        m_im = din[3];
        n_flag = 0;
      end
      if (we && addr[3:2] == 2'd1) m_pre = din;
      m_en = n_en; m_flag = n_flag; m_cnt = n_cnt; m_k = nk;
    end
  end

  function automatic logic [31:0] exp_dout(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_pre;
      2'd2:    return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_dout", dout, exp_dout(addr));
    chk("model_irq", {31'd0, irq}, {31'd0, m_flag & m_im});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a,
                        input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, dout, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    chk(name, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    logic [1:0] sel;
    repeat (10) tick();
    reset = 1'b0;
    rd_chk("rst_ctrl", 32'h0, 32'h0);
    rd_chk("rst_pre", 32'h4, 32'h0);
    rd_chk("rst_cnt", 32'h8, 32'h0);
    irq_chk("rst_irq", 1'b0);

    // one-shot, PRESET=5
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      rd_chk("os_count", 32'h8, 32'(5 - i));
    end
    tick();
    irq_chk("os_irq_rise", 1'b1);
    tick();
    rd_chk("os_ctrl_en_clr", 32'h0, 32'h8);
    irq_chk("os_irq_hold", 1'b1);
    wr(32'h0, 32'h8);
    irq_chk("os_irq_clear", 1'b0);

    // auto-reload, PRESET=3 then 6
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    for (int i = 1; i <= 5; i++) begin
      tick();
      irq_chk("ar_first", i == 5);
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      irq_chk("ar_period5", (i % 5) == 0);
    end
    tick();
    wr(32'h4, 32'd6);
    for (int i = 1; i <= 16; i++) begin
      tick();
      irq_chk("ar_period8", (i == 3) || (i == 11));
    end
    wr(32'h0, 32'h0);
    repeat (3) tick();

    // masked, PRESET=2
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h1);
    repeat (6) begin
      tick();
      irq_chk("mask_irq", 1'b0);
    end
    rd_chk("mask_count", 32'h8, 32'd0);
    wr(32'h0, 32'h8);
    irq_chk("mask_flag_clr", 1'b0);

    // pause, read-only COUNT, restart from PRESET
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h1);
    repeat (5) tick();
    wr(32'h0, 32'h0);
    rd_chk("pause_at6", 32'h8, 32'd6);
    tick();
    rd_chk("pause_hold", 32'h8, 32'd6);
    wr(32'h8, 32'h55);
    rd_chk("count_ro", 32'h8, 32'd6);
    repeat (3) tick();
    rd_chk("pause_hold2", 32'h8, 32'd6);
    wr(32'h0, 32'h1);
    tick();
    tick();
    rd_chk("resume_reload", 32'h8, 32'd10);
    wr(32'h0, 32'h0);
    repeat (3) tick();

    // reset mid-count in auto-reload
    wr(32'h4, 32'd5);
    wr(32'h0, 32'hB);
    repeat (4) tick();
    rd_chk("mid_count3", 32'h8, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_chk("mr_ctrl", 32'h0, 32'h0);
    rd_chk("mr_pre", 32'h4, 32'h0);
    rd_chk("mr_cnt", 32'h8, 32'h0);
    irq_chk("mr_irq", 1'b0);
    repeat (6) tick();
    rd_chk("mr_no_count", 32'h8, 32'h0);
    rd_chk("mr_ctrl_idle", 32'h0, 32'h0);

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      we = ($urandom_range(0, 3) == 0);
      sel = 2'($urandom_range(0, 3));
      addr = $urandom();
      addr[3:2] = sel;
      if (sel == 2'd0) begin
        din = $urandom();
        din[0] = ($urandom_range(0, 3) != 0);
      end else if (sel == 2'd1) begin
        din = $urandom_range(0, 7);
      end else begin
        din = $urandom();
      end
      tick();
    end
    reset = 1'b0;
    we = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
